snn_sched_ctrl: RTL and testbench
=================================

Name: snn_sched_ctrl

Overview:
- Central sequencer for the two-image SNN feature datapath: 3x3 conv, divide-quantise, 2x2 max-pool, 2x2 FC, divide-quantise, L1 distance.
- Replaces scattered per-register `cnt ==` decodes with one frame FSM and counter that drives every write-enable, index, shared-resource select and clock-gate enable.
- Sits beside the datapath; the datapath consumes its outputs combinationally in the same cycle.

Parameters:
- ERR_EN, 1, 1 = enable the in_valid protocol check and abort; 0 = ignore in_valid drops mid-frame.
- FRAME_LAST, 78, last frame-cycle index. Fixed by the schedule; a value other than 78 is unsupported.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input stream valid; high for 72 contiguous cycles per frame
- cg_en  in  1  1 = clock gating active; 0 = all gate_en forced to 1
- busy  out  1  frame in progress
- fcnt  out  7  current frame cycle, 0..78
- img_we / img_idx  out  1 / 6  image pixel write, index = fcnt mod 36
- ker_we / ker_idx  out  1 / 4  kernel write, 0..8
- wgt_we / wgt_idx  out  1 / 2  weight write, 0..3
- mul_src  out  2  multiplier array owner: 0 idle, 1 conv, 2 fc
- win_idx  out  4  conv window index, 0..15 (row-major over 4x4 output)
- div_src / div_sel  out  1 / 2  divider: 0 = conv/2295, 1 = fc[div_sel]/510
- q44_we / q44_idx  out  1 / 4  4x4 quantised map write
- pool_we / pool_idx  out  1 / 2  max-pool result write
- fc_we / fc_pair  out  1 / 1  fc write; fc_pair 0 = fc0/fc1, 1 = fc2/fc3
- q41_we / q41_bank / q41_idx  out  1 / 1 / 2  4x1 vector write; bank 0 = image1, 1 = image2
- l1_strobe  out  1  capture L1 result; the datapath registers out_valid from this
- gate_en  out  7  per-group clock enable: [0] image, [1] ker, [2] wgt, [3] q44, [4] pool, [5] fc, [6] q41
- err  out  1  one-cycle pulse on protocol abort

Behaviour:
- FSM states:
  - IDLE: fcnt = 0.
  - RUN1: fcnt 0..35.
  - RUN2: fcnt 36..71.
  - DRAIN: fcnt 72..78.
- Transitions:
  - IDLE goes to RUN1 when in_valid = 1.
  - fcnt increments by 1 every cycle while not IDLE.
  - At fcnt = 78 the next state is IDLE and fcnt becomes 0.
- Frame start is zero latency: in IDLE with in_valid = 1, the decode behaves as fcnt = 0 in that same cycle (img_we = ker_we = wgt_we = 1, all indices 0), and busy = 1.
- All outputs are combinational decodes of the registered state/fcnt, plus in_valid in IDLE only.
- Decode windows, stated for image 1; image 2 applies the same window at fcnt + 36 unless noted:
  - img_we: 0..71.
  - ker_we: 0..8.
  - wgt_we: 0..3.
  - conv: mul_src = 1 at 21..36, win_idx = fcnt - 21.
  - q44_we at 22..37, q44_idx = fcnt - 22, div_src = 0.
  - pool_we at 28/30/36/38, pool_idx 0/1/2/3.
  - fc_we with mul_src = 2 at 37 (fc_pair 0) and 39 (fc_pair 1).
  - q41_we with div_src = 1 at 38..41, div_sel = q41_idx = fcnt - 38, q41_bank = 0 (bank 1 for image 2).
  - l1_strobe: 78 only.
  - All other cycles: every enable is 0, indices are 0, mul_src = 0.
- Overlap rule: fcnt 37 carries both the last q44 write (div_src = 0) and the FC multiply. This is legal; the multiplier and divider are distinct resources.
- gate_en[g] = cg_en ? (write-enable of group g) : 1. It is the same cycle as the write, because the downstream ICG latches on clock low.
- Abort (ERR_EN = 1): in_valid = 0 while in RUN1/RUN2 means:
  - all enables for that cycle are suppressed;
  - the next state is IDLE with fcnt = 0, and err = 1 for that one following cycle;
  - no l1_strobe is issued.
- in_valid during DRAIN is ignored. A new frame may start in the cycle after fcnt = 78.
- rst_n = 0 at any edge, including mid-frame, gives on the next edge: state IDLE, fcnt 0, err 0. All outputs then decode to IDLE, so busy 0, enables 0, and gate_en = {7{~cg_en}}.

Decomposition:
- Package snn_pkg:
  - mul_src encoding (MS_IDLE, MS_CONV, MS_FC);
  - state enum;
  - gate group index constants;
  - window boundary constants (21, 22, 28, 30, 36, 37, 38, 39, 41, 72, 78) and IMG_OFS = 36.
- One sub-module, snn_win_dec: a pure combinational decode of (fcnt mod 36 offset, phase) into enables and indices. The top keeps the FSM, counter and abort logic.

Test Plan:
- Reset, then in_valid high for 72 cycles -> img_we high 72 cycles with img_idx wrapping 35 -> 0 at fcnt 36; l1_strobe exactly at fcnt 78; busy low at 79.
- Same frame, monitor pool and conv decodes -> pool_we at fcnt 28, 30, 36, 38, 64, 66, 72, 74 with idx 0..3; mul_src = 1 for 32 cycles total; win_idx at fcnt 26 = 5.
- Same frame, monitor fc/q41 decodes -> fc_we at fcnt 37, 39, 73, 75; q41_bank = 1 at fcnt 74..77 with div_sel 0..3.
- cg_en = 0, then cg_en = 1 across a frame -> gate_en = 7'h7F constantly, then gate_en[1] high only at fcnt 0..8 and [6] only at 38..41 and 74..77.
- in_valid dropped at fcnt 40 -> err pulse in the next cycle, state IDLE, no l1_strobe; a new frame started 2 cycles later completes normally.
- rst_n low at fcnt 50 for one cycle -> fcnt 0, busy 0 after the edge; back-to-back frames (in_valid at the cycle after fcnt 78) -> second l1_strobe 79 cycles after the first.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared encodings and schedule constants for the SNN feature-datapath sequencer.
package snn_pkg;

   // Frame phases of the sequencer
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN1  = 2'd1,
      ST_RUN2  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Multiplier array owner
   localparam logic [1:0] MS_IDLE = 2'd0;
   localparam logic [1:0] MS_CONV = 2'd1;
   localparam logic [1:0] MS_FC   = 2'd2;

   // Clock-gate group positions in gate_en
   localparam int unsigned GG_IMG  = 0;
   localparam int unsigned GG_KER  = 1;
   localparam int unsigned GG_WGT  = 2;
   localparam int unsigned GG_Q44  = 3;
   localparam int unsigned GG_POOL = 4;
   localparam int unsigned GG_FC   = 5;
   localparam int unsigned GG_Q41  = 6;
   localparam int unsigned N_GATE  = 7;

   // Window boundaries, relative to the start of an image
   localparam logic [6:0] KER_LAST  = 7'd8;
   localparam logic [6:0] WGT_LAST  = 7'd3;
   localparam logic [6:0] W_CONV_LO = 7'd21;
   localparam logic [6:0] W_Q44_LO  = 7'd22;
   localparam logic [6:0] W_POOL0   = 7'd28;
   localparam logic [6:0] W_POOL1   = 7'd30;
   localparam logic [6:0] W_CONV_HI = 7'd36;
   localparam logic [6:0] W_POOL2   = 7'd36;
   localparam logic [6:0] W_Q44_HI  = 7'd37;
   localparam logic [6:0] W_FC0     = 7'd37;
   localparam logic [6:0] W_Q41_LO  = 7'd38;
   localparam logic [6:0] W_POOL3   = 7'd38;
   localparam logic [6:0] W_FC1     = 7'd39;
   localparam logic [6:0] W_Q41_HI  = 7'd41;
   localparam logic [6:0] W_DRAIN   = 7'd72;
   localparam logic [6:0] W_LAST    = 7'd78;
   localparam logic [6:0] IMG_OFS   = 7'd36;

   // Everything one frame cycle drives into the datapath
   typedef struct packed {
      logic       img_we;
      logic [5:0] img_idx;
      logic       ker_we;
      logic [3:0] ker_idx;
      logic       wgt_we;
      logic [1:0] wgt_idx;
      logic [1:0] mul_src;
      logic [3:0] win_idx;
      logic       div_src;
      logic [1:0] div_sel;
      logic       q44_we;
      logic [3:0] q44_idx;
      logic       pool_we;
      logic [1:0] pool_idx;
      logic       fc_we;
      logic       fc_pair;
      logic       q41_we;
      logic       q41_bank;
      logic [1:0] q41_idx;
      logic       l1_strobe;
   } dec_t;

endpackage

// File: rtl/snn_win_dec.sv
// Pure combinational decode of a frame position (offset within a 36-cycle
// phase, plus phase number) into every datapath enable and index.
module snn_win_dec
   import snn_pkg::*;
(
   input  logic [5:0] offset,
   input  logic [1:0] phase,
   output dec_t       dec
);

   logic [6:0] full;
   logic [6:0] rel;
   logic       bank;

   // Rebuild the absolute frame cycle, pick the image it belongs to, then decode windows
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      dec  = '0;
      full = 7'(phase) * IMG_OFS + 7'(offset);

      // Image-1 windows end at 41 and image-2 windows start at 57, so 41 splits them cleanly
      if (full > W_Q41_HI) begin
         rel  = full - IMG_OFS;
         bank = 1'b1;
      end else begin
         rel  = full;
         bank = 1'b0;
      end

      // Pixels stream for both images; kernel and weights load once per frame
      if (full < W_DRAIN) begin
         dec.img_we  = 1'b1;
         dec.img_idx = offset;
      end
      if (full <= KER_LAST) begin
         dec.ker_we  = 1'b1;
         dec.ker_idx = full[3:0];
      end
      if (full <= WGT_LAST) begin
         dec.wgt_we  = 1'b1;
         dec.wgt_idx = full[1:0];
      end

      if (rel >= W_CONV_LO && rel <= W_CONV_HI) begin
         dec.mul_src = MS_CONV;
         dec.win_idx = 4'(rel - W_CONV_LO);
      end

      // Conv quantise trails the conv window by one cycle; div_src stays 0
      if (rel >= W_Q44_LO && rel <= W_Q44_HI) begin
         dec.q44_we  = 1'b1;
         dec.q44_idx = 4'(rel - W_Q44_LO);
      end

      if (rel == W_POOL0) begin
         dec.pool_we  = 1'b1;
         dec.pool_idx = 2'd0;
      end else if (rel == W_POOL1) begin
         dec.pool_we  = 1'b1;
         dec.pool_idx = 2'd1;
      end else if (rel == W_POOL2) begin
         dec.pool_we  = 1'b1;
         dec.pool_idx = 2'd2;
      end else if (rel == W_POOL3) begin
         dec.pool_we  = 1'b1;
         dec.pool_idx = 2'd3;
      end

      // FC shares the multiplier; 37 also carries the last q44 write on the divider
      if (rel == W_FC0) begin
         dec.fc_we   = 1'b1;
         dec.mul_src = MS_FC;
         dec.fc_pair = 1'b0;
      end else if (rel == W_FC1) begin
         dec.fc_we   = 1'b1;
         dec.mul_src = MS_FC;
         dec.fc_pair = 1'b1;
      end

      if (rel >= W_Q41_LO && rel <= W_Q41_HI) begin
         dec.q41_we   = 1'b1;
         dec.q41_bank = bank;
         dec.q41_idx  = 2'(rel - W_Q41_LO);
         dec.div_src  = 1'b1;
         dec.div_sel  = 2'(rel - W_Q41_LO);
      end

      dec.l1_strobe = (full == W_LAST);
   end

endmodule

// File: rtl/snn_sched_ctrl.sv
// Frame sequencer for the two-image SNN datapath: owns the frame FSM,
// cycle counter and protocol abort, and drives all datapath controls.
module snn_sched_ctrl
   import snn_pkg::*;
#(
   parameter bit          ERR_EN     = 1'b1,
   parameter int unsigned FRAME_LAST = 78
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       cg_en,
   output logic       busy,
   output logic [6:0] fcnt,
   output logic       img_we,
   output logic [5:0] img_idx,
   output logic       ker_we,
   output logic [3:0] ker_idx,
   output logic       wgt_we,
   output logic [1:0] wgt_idx,
   output logic [1:0] mul_src,
   output logic [3:0] win_idx,
   output logic       div_src,
   output logic [1:0] div_sel,
   output logic       q44_we,
   output logic [3:0] q44_idx,
   output logic       pool_we,
   output logic [1:0] pool_idx,
   output logic       fc_we,
   output logic       fc_pair,
   output logic       q41_we,
   output logic       q41_bank,
   output logic [1:0] q41_idx,
   output logic       l1_strobe,
   output logic [6:0] gate_en,
   output logic       err
);

   localparam logic [6:0] LAST = 7'(FRAME_LAST);

   state_t     state_q, state_nx;
   logic [6:0] fcnt_q, fcnt_nx;
   logic       err_q;
   logic       abort;
   logic       active;
   logic [5:0] offset;
   logic [1:0] phase;
   dec_t       dec_raw, dec;
   logic [N_GATE-1:0] we_vec;

   // Dropping in_valid while an image is still streaming kills the frame
   assign abort  = ERR_EN && (state_q == ST_RUN1 || state_q == ST_RUN2) && !in_valid;
   // In IDLE the frame starts this very cycle when in_valid rises
   assign active = (state_q == ST_IDLE) ? in_valid : !abort;

   // Split the counter into the phase-relative position the decoder consumes
   always_comb begin
      offset = '0;
      phase  = 2'd0;
      case (state_q)
         ST_RUN1:  begin offset = fcnt_q[5:0];             phase = 2'd0; end
         ST_RUN2:  begin offset = 6'(fcnt_q - IMG_OFS);    phase = 2'd1; end
         ST_DRAIN: begin offset = 6'(fcnt_q - W_DRAIN);    phase = 2'd2; end
         default:  begin offset = '0;                      phase = 2'd0; end
      endcase
   end

   snn_win_dec u_win_dec (
      .offset (offset),
      .phase  (phase),
      .dec    (dec_raw)
   );

   assign dec = active ? dec_raw : '0;

   // Frame FSM and counter next-state
   always_comb begin
      state_nx = state_q;
      fcnt_nx  = fcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_nx = ST_RUN1;
               fcnt_nx  = 7'd1;
            end
         end
         ST_RUN1: begin
            if (abort) begin
               state_nx = ST_IDLE;
               fcnt_nx  = '0;
            end else begin
               fcnt_nx = fcnt_q + 7'd1;
               if (fcnt_q == IMG_OFS - 7'd1) state_nx = ST_RUN2;
            end
         end
         ST_RUN2: begin
            if (abort) begin
               state_nx = ST_IDLE;
               fcnt_nx  = '0;
            end else begin
               fcnt_nx = fcnt_q + 7'd1;
               if (fcnt_q == W_DRAIN - 7'd1) state_nx = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fcnt_q == LAST) begin
               state_nx = ST_IDLE;
               fcnt_nx  = '0;
            end else begin
               fcnt_nx = fcnt_q + 7'd1;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            fcnt_nx  = '0;
         end
      endcase
   end

   // State, counter and abort pulse registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         fcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state_q <= state_nx;
         fcnt_q  <= fcnt_nx;
         err_q   <= abort;
      end
   end

   // Group write-enables feed the clock gates in the same cycle as the write
   always_comb begin
      we_vec          = '0;
      we_vec[GG_IMG]  = dec.img_we;
      we_vec[GG_KER]  = dec.ker_we;
      we_vec[GG_WGT]  = dec.wgt_we;
      we_vec[GG_Q44]  = dec.q44_we;
      we_vec[GG_POOL] = dec.pool_we;
      we_vec[GG_FC]   = dec.fc_we;
      we_vec[GG_Q41]  = dec.q41_we;
   end

   assign gate_en   = cg_en ? we_vec : {N_GATE{1'b1}};
   assign busy      = (state_q != ST_IDLE) || in_valid;
   assign fcnt      = fcnt_q;
   assign err       = err_q;
   assign img_we    = dec.img_we;
   assign img_idx   = dec.img_idx;
   assign ker_we    = dec.ker_we;
   assign ker_idx   = dec.ker_idx;
   assign wgt_we    = dec.wgt_we;
   assign wgt_idx   = dec.wgt_idx;
   assign mul_src   = dec.mul_src;
   assign win_idx   = dec.win_idx;
   assign div_src   = dec.div_src;
   assign div_sel   = dec.div_sel;
   assign q44_we    = dec.q44_we;
   assign q44_idx   = dec.q44_idx;
   assign pool_we   = dec.pool_we;
   assign pool_idx  = dec.pool_idx;
   assign fc_we     = dec.fc_we;
   assign fc_pair   = dec.fc_pair;
   assign q41_we    = dec.q41_we;
   assign q41_bank  = dec.q41_bank;
   assign q41_idx   = dec.q41_idx;
   assign l1_strobe = dec.l1_strobe;

endmodule

// File: tb/tb_snn_sched_ctrl.sv
// Self-checking bench for snn_sched_ctrl: a frame-position model predicts
// every output each cycle; directed frames pin the schedule with literals.
module tb_snn_sched_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, in_valid, cg_en;
   logic       busy, img_we, ker_we, wgt_we, div_src, q44_we, pool_we;
   logic       fc_we, fc_pair, q41_we, q41_bank, l1_strobe, err;
   logic [6:0] fcnt, gate_en;
   logic [5:0] img_idx;
   logic [3:0] ker_idx, win_idx, q44_idx;
   logic [1:0] wgt_idx, mul_src, div_sel, pool_idx, q41_idx;

   snn_sched_ctrl #(.ERR_EN(1'b1), .FRAME_LAST(78)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cg_en(cg_en),
      .busy(busy), .fcnt(fcnt),
      .img_we(img_we), .img_idx(img_idx), .ker_we(ker_we), .ker_idx(ker_idx),
      .wgt_we(wgt_we), .wgt_idx(wgt_idx), .mul_src(mul_src), .win_idx(win_idx),
      .div_src(div_src), .div_sel(div_sel), .q44_we(q44_we), .q44_idx(q44_idx),
      .pool_we(pool_we), .pool_idx(pool_idx), .fc_we(fc_we), .fc_pair(fc_pair),
      .q41_we(q41_we), .q41_bank(q41_bank), .q41_idx(q41_idx),
      .l1_strobe(l1_strobe), .gate_en(gate_en), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   // Model state: frame position (-1 = idle) and pending abort pulse
   int m_pos = -1;
   bit m_err = 1'b0;

   int pool_cyc[8] = '{28, 30, 36, 38, 64, 66, 72, 74};
   int fc_cyc[4]   = '{37, 39, 73, 75};

   typedef struct {
      int busy, fcnt, err;
      int img_we, img_idx, ker_we, ker_idx, wgt_we, wgt_idx;
      int mul_src, win_idx, div_src, div_sel, q44_we, q44_idx;
      int pool_we, pool_idx, fc_we, fc_pair;
      int q41_we, q41_bank, q41_idx, l1, gate;
   } exp_t;

   // Event logs gathered by the compare process
   int pool_f[$], pool_i[$], fc_f[$], fc_p[$], q41b_f[$], q41b_s[$], l1_cyc[$], l1_f[$];
   int err_cyc[$];
   int cnt_img, cnt_conv, cnt_g1, cnt_g6, cnt_busy, cnt_not7f;
   int win26, idx35, idx36;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         if (n_errs <= 40)
            $display("FAIL %s cyc=%0d: got %0d want %0d", name, cyc, act, exp);
      end
   endtask

   // Expected outputs from the frame position, written straight from the schedule table
   function automatic exp_t model_out(int pos, bit iv, bit cg, bit merr);
      exp_t e;
      int   p, b, g;
      bit   act;
      e = '{default: 0};
      p = (pos < 0) ? 0 : pos;
      act = (pos < 0) ? iv : !(pos <= 71 && !iv);
      e.busy = (pos >= 0 || iv) ? 1 : 0;
      e.fcnt = p;
      e.err  = merr;
      if (act) begin
         if (p <= 71) begin e.img_we = 1; e.img_idx = p % 36; end
         if (p <= 8)  begin e.ker_we = 1; e.ker_idx = p; end
         if (p <= 3)  begin e.wgt_we = 1; e.wgt_idx = p; end
         for (int k = 0; k < 2; k++) begin
            b = 36 * k;
            if (p >= b + 21 && p <= b + 36) begin e.mul_src = 1; e.win_idx = p - b - 21; end
            if (p >= b + 22 && p <= b + 37) begin e.q44_we = 1; e.q44_idx = p - b - 22; end
            if (p >= b + 38 && p <= b + 41) begin
               e.q41_we = 1; e.q41_bank = k; e.q41_idx = p - b - 38;
               e.div_src = 1; e.div_sel = p - b - 38;
            end
         end
         for (int i = 0; i < 8; i++)
            if (p == pool_cyc[i]) begin e.pool_we = 1; e.pool_idx = i % 4; end
         for (int i = 0; i < 4; i++)
            if (p == fc_cyc[i]) begin e.fc_we = 1; e.mul_src = 2; e.fc_pair = i % 2; end
         if (p == 78) e.l1 = 1;
      end
      g = e.img_we + 2 * e.ker_we + 4 * e.wgt_we + 8 * e.q44_we
        + 16 * e.pool_we + 32 * e.fc_we + 64 * e.q41_we;
      e.gate = cg ? g : 127;
      return e;
   endfunction

   // Model advances on the same edge as the DUT
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         m_pos <= -1; m_err <= 1'b0;
      end else if (m_pos < 0) begin
         m_pos <= in_valid ? 1 : -1; m_err <= 1'b0;
      end else if (m_pos <= 71 && !in_valid) begin
         m_pos <= -1; m_err <= 1'b1;
      end else if (m_pos == 78) begin
         m_pos <= -1; m_err <= 1'b0;
      end else begin
         m_pos <= m_pos + 1; m_err <= 1'b0;
      end
   end

   // Compare every output mid-cycle and log schedule events
   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         e = model_out(m_pos, in_valid, cg_en, m_err);
         check("busy", busy, e.busy);
         check("fcnt", fcnt, e.fcnt);
         check("err", err, e.err);
         check("img_we", img_we, e.img_we);
         check("img_idx", img_idx, e.img_idx);
         check("ker_we", ker_we, e.ker_we);
         check("ker_idx", ker_idx, e.ker_idx);
         check("wgt_we", wgt_we, e.wgt_we);
         check("wgt_idx", wgt_idx, e.wgt_idx);
         check("mul_src", mul_src, e.mul_src);
         check("win_idx", win_idx, e.win_idx);
         check("div_src", div_src, e.div_src);
         check("div_sel", div_sel, e.div_sel);
         check("q44_we", q44_we, e.q44_we);
         check("q44_idx", q44_idx, e.q44_idx);
         check("pool_we", pool_we, e.pool_we);
         check("pool_idx", pool_idx, e.pool_idx);
         check("fc_we", fc_we, e.fc_we);
         check("fc_pair", fc_pair, e.fc_pair);
         check("q41_we", q41_we, e.q41_we);
         check("q41_bank", q41_bank, e.q41_bank);
         check("q41_idx", q41_idx, e.q41_idx);
         check("l1_strobe", l1_strobe, e.l1);
         check("gate_en", gate_en, e.gate);

         if (pool_we) begin pool_f.push_back(int'(fcnt)); pool_i.push_back(int'(pool_idx)); end
         if (fc_we) begin fc_f.push_back(int'(fcnt)); fc_p.push_back(int'(fc_pair)); end
         if (q41_we && q41_bank) begin q41b_f.push_back(int'(fcnt)); q41b_s.push_back(int'(div_sel)); end
         if (l1_strobe) begin l1_cyc.push_back(cyc); l1_f.push_back(int'(fcnt)); end
         if (err) err_cyc.push_back(cyc);
         if (img_we) cnt_img++;
         if (mul_src == 2'd1) cnt_conv++;
         if (gate_en[1]) cnt_g1++;
         if (gate_en[6]) cnt_g6++;
         if (busy) cnt_busy++;
         if (busy && gate_en != 7'h7F) cnt_not7f++;
         if (busy && fcnt == 7'd26) win26 = int'(win_idx);
         if (busy && fcnt == 7'd35) idx35 = int'(img_idx);
         if (busy && fcnt == 7'd36) idx36 = int'(img_idx);
      end
   end

   task automatic clear_logs();
      pool_f.delete(); pool_i.delete(); fc_f.delete(); fc_p.delete();
      q41b_f.delete(); q41b_s.delete(); l1_cyc.delete(); l1_f.delete(); err_cyc.delete();
      cnt_img = 0; cnt_conv = 0; cnt_g1 = 0; cnt_g6 = 0; cnt_busy = 0; cnt_not7f = 0;
      win26 = -1; idx35 = -1; idx36 = -1;
   endtask

   // Hold in_valid at v for n cycles; inputs change 1 time unit after the edge
   task automatic drive(input bit v, input int n);
      repeat (n) begin
         in_valid = v;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int pool_exp_i[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      rst_n = 1'b0; in_valid = 1'b0; cg_en = 1'b1;
      clear_logs();
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;
      check("rst_fcnt", fcnt, 0);
      check("rst_busy", busy, 0);
      check("rst_gate_en", gate_en, 0);
      check("rst_err", err, 0);

      // Frame with clock gating off: every gate stays open
      cg_en = 1'b0;
      clear_logs();
      drive(1'b1, 72); drive(1'b0, 10);
      check("cg0_busy_cycles", cnt_busy, 79);
      check("cg0_gate_closed_cycles", cnt_not7f, 0);

      // Frame with clock gating on: pin the whole schedule
      cg_en = 1'b1;
      clear_logs();
      drive(1'b1, 72); drive(1'b0, 10);
      check("img_we_cycles", cnt_img, 72);
      check("img_idx_at_35", idx35, 35);
      check("img_idx_at_36", idx36, 0);
      check("conv_cycles", cnt_conv, 32);
      check("win_idx_at_26", win26, 5);
      check("pool_count", pool_f.size(), 8);
      for (int i = 0; i < 8 && i < pool_f.size(); i++) begin
         check("pool_fcnt", pool_f[i], pool_cyc[i]);
         check("pool_idx_seq", pool_i[i], pool_exp_i[i]);
      end
      check("fc_count", fc_f.size(), 4);
      for (int i = 0; i < 4 && i < fc_f.size(); i++) begin
         check("fc_fcnt", fc_f[i], fc_cyc[i]);
         check("fc_pair_seq", fc_p[i], i % 2);
      end
      check("q41_bank1_count", q41b_f.size(), 4);
      for (int i = 0; i < 4 && i < q41b_f.size(); i++) begin
         check("q41_bank1_fcnt", q41b_f[i], 74 + i);
         check("q41_bank1_div_sel", q41b_s[i], i);
      end
      check("l1_count", l1_f.size(), 1);
      if (l1_f.size() > 0) check("l1_fcnt", l1_f[0], 78);
      check("gate1_cycles", cnt_g1, 9);
      check("gate6_cycles", cnt_g6, 8);

      // Abort at fcnt 40, restart two cycles later
      clear_logs();
      drive(1'b1, 40); drive(1'b0, 2); drive(1'b1, 72); drive(1'b0, 10);
      check("abort_err_pulses", err_cyc.size(), 1);
      check("abort_l1_count", l1_cyc.size(), 1);
      if (err_cyc.size() > 0 && l1_cyc.size() > 0)
         check("restart_l1_offset", l1_cyc[0] - err_cyc[0], 79);

      // Reset in the middle of a frame
      clear_logs();
      drive(1'b1, 50);
      in_valid = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("midrst_fcnt", fcnt, 0);
      check("midrst_busy", busy, 0);
      drive(1'b0, 3);
      check("midrst_l1_count", l1_cyc.size(), 0);
      check("midrst_err_count", err_cyc.size(), 0);

      // Back-to-back frames
      clear_logs();
      drive(1'b1, 72); drive(1'b0, 7); drive(1'b1, 72); drive(1'b0, 10);
      check("b2b_l1_count", l1_cyc.size(), 2);
      if (l1_cyc.size() == 2) check("b2b_l1_spacing", l1_cyc[1] - l1_cyc[0], 79);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
